// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, one-byte holding register in front of the shift register.
// Serial line is registered; busy_o reflects the FSM state, so it leads tx by one cycle.
module uart_tx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx,
  output logic       busy_o
);

  localparam int unsigned ClksPerBit = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  // A bit period shorter than two clocks cannot be timed by the counter.
  if (ClksPerBit < 2) begin : g_bad_cfg
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            tx_q, tx_d;
  logic            accept, load, cnt_end;

  // Holding register handshake: accept only while empty; a load into the shifter frees it.
  always_comb begin
    accept      = valid_i & ~hold_full_q;
    hold_d      = accept ? data_i : hold_q;
    hold_full_d = accept | (hold_full_q & ~load);
  end

  // Frame sequencer: next state, bit timing counter, bit index and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
    cnt_end   = (cnt_q == CntMax);
    case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          state_d = StStart;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      StStart: begin
        if (cnt_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_end) begin
          cnt_d = '0;
          // A waiting byte starts its frame immediately, with no idle cycle in between.
          if (hold_full_q) begin
            state_d = StStart;
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      shift_d = hold_q;
    end
  end

  // Serial line level for the current state, registered so tx never glitches.
  always_comb begin
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and discards a pending byte.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  assign ready_o = ~hold_full_q;
  assign busy_o  = (state_q != StIdle);
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 10 with a byte scoreboard and serial monitor.
module tb_uart_tx;

  localparam int unsigned ClkFreq = 1000;
  localparam int unsigned Baud    = 100;
  localparam int          Cpb     = 10;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       tx;
  logic       busy_o;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  int         busy_cnt  = 0;
  int         busy_fall = 0;
  logic       busy_prev = 1'b0;

  uart_tx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk    (clk),
    .rst_   (rst_),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx     (tx),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  // Busy-cycle and busy-falling-edge counters, sampled mid-cycle.
  always @(negedge clk) begin
    busy_prev <= busy_o;
    if (busy_o) busy_cnt <= busy_cnt + 1;
    if (busy_prev && !busy_o) busy_fall <= busy_fall + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decodes frames off tx at mid-bit and compares against the scoreboard head.
  task automatic monitor();
    logic [9:0] bits;
    logic [7:0] exp;
    bit         abort;
    forever begin
      @(negedge clk);
      if (!rst_ && tx === 1'b0) begin
        abort = 1'b0;
        bits  = '0;
        for (int k = 0; k < 10; k++) begin
          repeat ((k == 0) ? Cpb / 2 : Cpb) begin
            @(negedge clk);
            if (rst_) abort = 1'b1;
          end
          if (abort) break;
          bits[k] = tx;
        end
        if (!abort) begin
          exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          chk("rx_start_bit", 32'(bits[0]), 32'd0);
          chk("rx_data", 32'(bits[8:1]), 32'(exp));
          chk("rx_stop_bit", 32'(bits[9]), 32'd1);
        end
      end
    end
  endtask

  // Called at a negedge; holds valid_i until ready_o, returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b);
    int n = 0;
    valid_i = 1'b1;
    data_i  = b;
    while (!ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 32'(n < 3000), 32'd1);
    sb.push_back(b);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || !ready_o) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 5000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b0;
    int f0;
    int viol;
    int n;
    int lo;
    int hi;

    fork
      monitor();
    join_none

    // Reset with valid_i asserted: nothing may be accepted.
    rst_    = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_    = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Idle stability.
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0) viol++;
    end
    chk("idle_stable", 32'(viol), 32'd0);

    // 0x29: accept at edge N, START at N+1, tx falls at N+2, busy for 10 bit times.
    b0      = busy_cnt;
    valid_i = 1'b1;
    data_i  = 8'h29;
    chk("lat_ready_before", 32'(ready_o), 32'd1);
    sb.push_back(8'h29);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("lat_n_ready", 32'(ready_o), 32'd0);
    chk("lat_n_busy", 32'(busy_o), 32'd0);
    chk("lat_n_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_n1_busy", 32'(busy_o), 32'd1);
    chk("lat_n1_ready", 32'(ready_o), 32'd1);
    chk("lat_n1_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_n2_tx", 32'(tx), 32'd0);
    @(negedge clk);
    wait_idle();
    chk("busy_single_frame", 32'(busy_cnt - b0), 32'(10 * Cpb));
    chk("sb_drained_29", 32'(sb.size()), 32'd0);

    // Back-to-back 0x55, 0xA3: one continuous busy period of two frames.
    b0 = busy_cnt;
    f0 = busy_fall;
    send(8'h55);
    send(8'hA3);
    wait_idle();
    chk("b2b_busy_cycles", 32'(busy_cnt - b0), 32'(20 * Cpb));
    chk("b2b_busy_falls", 32'(busy_fall - f0), 32'd1);
    chk("sb_drained_b2b", 32'(sb.size()), 32'd0);

    // valid_i held with data_i changing every cycle: only bytes offered while ready are sent.
    b0      = busy_cnt;
    valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data_i = 8'($urandom);
      if (ready_o) sb.push_back(data_i);
      @(negedge clk);
    end
    valid_i = 1'b0;
    wait_idle();
    chk("hold_busy_cycles", 32'(busy_cnt - b0), 32'(20 * Cpb));
    chk("sb_drained_hold", 32'(sb.size()), 32'd0);

    // Reset during data bit 4 with a second byte pending.
    send(8'h3C);
    send(8'h81);
    repeat (5 * Cpb + 4) @(negedge clk);
    rst_    = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h77;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_    = 1'b0;
    valid_i = 1'b0;
    sb.delete();
    repeat (3 * Cpb) @(negedge clk);
    chk("midrst_no_resume", 32'(busy_o), 32'd0);
    send(8'h5A);
    wait_idle();
    chk("sb_drained_rst", 32'(sb.size()), 32'd0);

    // 0xFF: 10 cycles low, then 90 cycles high.
    send(8'hFF);
    n = 0;
    while (tx === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lo = 0;
    while (tx === 1'b0 && lo < 50) begin
      @(negedge clk);
      lo++;
    end
    chk("ff_low_cycles", 32'(lo), 32'(Cpb));
    hi = 0;
    repeat (9 * Cpb) begin
      if (tx === 1'b1) hi++;
      @(negedge clk);
    end
    chk("ff_high_cycles", 32'(hi), 32'(9 * Cpb));
    wait_idle();
    chk("sb_drained_final", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 SHALL have port data_i  input  8  byte to transmit, sampled on accept.
REQ-006 SHALL have port valid_i  input  1  data_i valid request.
REQ-007 SHALL have port ready_o  output  1  holding register empty, byte can be accepted.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy_o  output  1  frame in progress on tx.

Function
REQ-010 SHALL derive CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD, giving 10417 at defaults; bit counter width = ceil(log2(CLKS_PER_BIT)).
REQ-011 SHALL treat CLKS_PER_BIT < 2 as an illegal configuration and flag it in elaboration checks.
REQ-012 SHALL accept a byte on any rising edge with valid_i=1 and ready_o=1, loading data_i into a one-byte holding register and driving ready_o=0 from the next cycle.
REQ-013 SHALL ignore valid_i while ready_o=0; data_i changes while ready_o=0 have no effect.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1, busy_o=0; moves to START on the cycle after the holding register becomes full.
REQ-016 On IDLE->START, SHALL move holding register into the shift register and set ready_o=1 on that same edge.
REQ-017 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-018 DATA: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; bit index 0..7, move to STOP after bit 7.
REQ-019 STOP: tx=1 for exactly CLKS_PER_BIT cycles (one stop bit, no parity).
REQ-020 End of STOP with holding register full: SHALL go directly to START with no idle cycle (back-to-back frames); otherwise to IDLE.
REQ-021 Latency: byte accepted at edge N with FSM in IDLE -> tx falls at edge N+2; full frame = 10*CLKS_PER_BIT cycles.
REQ-022 busy_o SHALL be 1 in START, DATA, STOP and 0 only in IDLE.
REQ-023 A byte accepted during an ongoing frame SHALL wait in the holding register and SHALL NOT disturb the current frame.
REQ-024 Accept and end-of-STOP on the same edge: new byte goes to holding register, then START per REQ-020 on the following edge.
REQ-025 tx SHALL be driven from a register (glitch-free).

Reset
REQ-026 rst_=1 SHALL immediately force tx=1, busy_o=0, ready_o=1, FSM=IDLE, holding register empty, counters cleared.
REQ-027 Reset mid-frame SHALL abort the frame (tx returns high at once); the pending byte is discarded.
REQ-028 valid_i SHALL be ignored while rst_=1; first accept possible on first edge after deassertion.

Verification
REQ-029 Reset then idle 1000 cycles -> tx=1, ready_o=1, busy_o=0 throughout.
REQ-030 Send 0x29 at defaults -> tx = 0,1,0,0,1,0,1,0,0,1 each held 10417 cycles; busy_o high 104170 cycles; the existing receiver outputs data_o=0x29.
REQ-031 Send 0x55 then 0xA3 back-to-back (second valid_i held until ready_o) -> stop bit of frame 1 followed immediately by start bit of frame 2, no idle gap, total busy 208340 cycles.
REQ-032 valid_i held high with changing data_i during a frame -> only the byte present when ready_o=1 is sent.
REQ-033 rst_ pulse during DATA bit 4 -> tx=1 within the same cycle, ready_o=1, next frame after reset transmits correctly.
REQ-034 CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10) send 0xFF -> start bit 10 cycles low, then 90 cycles high.
